// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned PC_WIDTH  = 9;
  localparam int unsigned INS_WIDTH = 32;

  localparam logic [INS_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned          PC_STEP   = 4;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_FULL
  } fetch_state_t;

  typedef struct packed {
    logic                 valid;
    logic [PC_WIDTH-1:0]  pc;
    logic [INS_WIDTH-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Handshaked instruction-memory port: the fetch stage is master, the memory is slave.
interface fetch_stage_if import fetch_pkg::*; #(
  parameter int unsigned PC_W  = PC_WIDTH,
  parameter int unsigned INS_W = INS_WIDTH
);

  logic             req;
  logic [PC_W-1:0]  addr;
  logic             gnt;
  logic             rvalid;
  logic [INS_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_buffer.sv
// Small in-order buffer for fetched {pc, instr} pairs that IF/ID cannot take yet.
module fetch_buffer import fetch_pkg::*; #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = PC_WIDTH + INS_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic             clear_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [Width-1:0] rd_data_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CntW'(Depth));
  assign rd_data_o = mem_q[0];

  // Entry 0 is always the head; a read shifts the rest down.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (rd_en_i && !empty_o) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      cnt_d = cnt_q - CntW'(1);
    end
    if (wr_en_i && (cnt_d != CntW'(Depth))) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (i == int'(cnt_d)) begin
          mem_d[i] = wr_data_i;
        end
      end
      cnt_d = cnt_d + CntW'(1);
    end
    if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight, drives IF/ID.
// Define FETCH_BUF_EN to replace the single hold register with a 2-entry FIFO.
module fetch_stage import fetch_pkg::*; #(
  parameter int unsigned PC_W  = PC_WIDTH,
  parameter int unsigned INS_W = INS_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  fetch_stage_if.master    imem_io,
  output logic             if_id_valid_o,
  output logic [PC_W-1:0]  if_id_pc_o,
  output logic [INS_W-1:0] if_id_instr_o
);

`ifdef FETCH_BUF_EN
  localparam int unsigned BufDepth = 2;
`else
  localparam int unsigned BufDepth = 1;
`endif
  localparam int unsigned EntW = PC_W + INS_W;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            stale_q, stale_d;
  logic            req_q, req_d;
  if_id_t          if_id_q, if_id_d;

  logic            fire, rsp, live_rsp, if_id_free, one_free;
  logic            buf_wr, buf_rd, buf_empty, buf_full;
  logic [EntW-1:0] buf_head;

  fetch_buffer #(
    .Depth (BufDepth),
    .Width (EntW)
  ) u_buffer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (buf_wr),
    .wr_data_i ({req_pc_q, imem_io.rdata}),
    .rd_en_i   (buf_rd),
    .clear_i   (redirect_valid_i),
    .empty_o   (buf_empty),
    .full_o    (buf_full),
    .rd_data_o (buf_head)
  );

  // req_q mirrors FS_REQ except in the first cycle after reset, when it is still low.
  assign fire       = req_q && imem_io.gnt;
  assign rsp        = (state_q == FS_WAIT) && imem_io.rvalid;
  assign live_rsp   = rsp && !stale_q;
  assign if_id_free = !if_id_q.valid || !stall_i;
  assign one_free   = (BufDepth == 1) ? buf_empty : (!buf_empty && !buf_full);

  // The buffered head always goes to IF/ID before a direct response, keeping program order.
  assign buf_rd = !redirect_valid_i && if_id_free && !buf_empty;
  assign buf_wr = !redirect_valid_i && live_rsp && (!if_id_free || !buf_empty);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    stale_d  = stale_q;
    if_id_d  = if_id_q;

    if (if_id_free) begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end
    if (buf_rd) begin
      if_id_d.valid = 1'b1;
      if_id_d.pc    = buf_head[EntW-1 -: PC_W];
      if_id_d.instr = buf_head[INS_W-1:0];
    end else if (if_id_free && live_rsp) begin
      if_id_d.valid = 1'b1;
      if_id_d.pc    = req_pc_q;
      if_id_d.instr = imem_io.rdata;
    end

    unique case (state_q)
      FS_REQ: begin
        if (fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_W'(PC_STEP);
          state_d  = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (rsp) begin
          stale_d = 1'b0;
          state_d = (buf_wr && !buf_rd && one_free) ? FS_FULL : FS_REQ;
        end
      end
      FS_FULL: begin
        if (buf_rd) begin
          state_d = FS_REQ;
        end
      end
      default: state_d = FS_REQ;
    endcase

    if (redirect_valid_i) begin
      pc_d          = {redirect_pc_i[PC_W-1:2], 2'b00};
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
      if (((state_q == FS_WAIT) && !imem_io.rvalid) || fire) begin
        stale_d = 1'b1;
        state_d = FS_WAIT;
      end else begin
        stale_d = 1'b0;
        state_d = FS_REQ;
      end
    end

    req_d = (state_d == FS_REQ);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= FS_REQ;
      pc_q     <= '0;
      req_pc_q <= '0;
      stale_q  <= 1'b0;
      req_q    <= 1'b0;
      if_id_q  <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      stale_q  <= stale_d;
      req_q    <= req_d;
      if_id_q  <= if_id_d;
    end
  end

  assign imem_io.req  = req_q;
  assign imem_io.addr = (state_q == FS_REQ) ? pc_q : req_pc_q;

  assign if_id_valid_o = if_id_q.valid;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_instr_o = if_id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory model feeds the DUT and a scoreboard
// of expected program-order PCs is checked whenever ID consumes an IF/ID entry.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned PcW  = 9;
  localparam int unsigned InsW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            redirect_valid;
  logic [PcW-1:0]  redirect_pc;
  logic            if_id_valid;
  logic [PcW-1:0]  if_id_pc;
  logic [InsW-1:0] if_id_instr;

  fetch_stage_if #(.PC_W(PcW), .INS_W(InsW)) imem ();

  fetch_stage #(.PC_W(PcW), .INS_W(InsW)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_io          (imem),
    .if_id_valid_o    (if_id_valid),
    .if_id_pc_o       (if_id_pc),
    .if_id_instr_o    (if_id_instr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] instr_of(input int unsigned a);
    logic [14:0] mix;
    logic [8:0]  lo;
    mix = 15'(a * 7) ^ 15'h1234;
    lo  = 9'(a);
    return {8'hC3, mix, lo};
  endfunction

  // Scoreboard: PCs that ID should see, in program order.
  int unsigned exp_q[$];

  function automatic void restart(input int unsigned target);
    exp_q.delete();
    exp_q.push_back(((target / 4) * 4) % 512);
  endfunction

  function automatic void topup();
    if (exp_q.size() == 0) exp_q.push_back(0);
    while (exp_q.size() < 16) exp_q.push_back((exp_q[$] + 4) % 512);
  endfunction

  // Monitor: runs just after each rising edge.
  int          cyc = 0;
  int          consumed = 0;
  bit          tput_mode = 0;
  int          tput_last = -1;
  logic        pv = 1'b0;
  logic [8:0]  ppc = '0;
  logic [31:0] pins = 32'h0;

  always @(posedge clk) begin
    int unsigned e;
    #1;
    cyc++;
    if (!tput_mode) tput_last = -1;
    if (!reset) begin
      if (redirect_valid) begin
        check("flush_valid", if_id_valid, 0);
        check("flush_instr", if_id_instr, NOP_INSTR);
        tput_last = -1;
      end else begin
        if (pv && !stall) begin
          consumed++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got pc %0h expected none", ppc);
          end else begin
            e = exp_q.pop_front();
            check("ifid_pc", ppc, e);
            check("ifid_instr", pins, instr_of(e));
          end
          if (tput_mode) begin
            if (tput_last >= 0) check("tput_gap", cyc - tput_last, 2);
            tput_last = cyc;
          end
        end
        if (pv && stall) begin
          check("hold_valid", if_id_valid, 1);
          check("hold_pc", if_id_pc, ppc);
          check("hold_instr", if_id_instr, pins);
        end
      end
      if (!if_id_valid) check("idle_nop", if_id_instr, NOP_INSTR);
    end
    pv   = if_id_valid;
    ppc  = if_id_pc;
    pins = if_id_instr;
  end

  // Memory model and stimulus state.
  logic        req_s = 1'b0;
  logic [8:0]  addr_s = '0;
  bit          outst = 0;
  int unsigned owait = 0;
  logic [8:0]  oaddr = '0;
  bit          chk_req = 0;
  int unsigned chk_addr = 0;
  int unsigned p_gnt = 100;
  int unsigned min_lat = 0;
  int unsigned max_lat = 0;

  task automatic step(input bit st, input bit rd, input int unsigned tgt);
    @(negedge clk);
    if (imem.rvalid) outst = 0;
    if (imem.gnt && req_s) begin
      outst = 1;
      oaddr = addr_s;
      owait = $urandom_range(max_lat, min_lat);
    end
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = $urandom();
    if (outst) begin
      if (owait == 0) begin
        imem.rvalid = 1'b1;
        imem.rdata  = instr_of(oaddr);
      end else begin
        owait--;
      end
    end
    req_s  = imem.req;
    addr_s = imem.addr;
    if (req_s) begin
      check("single_outstanding", outst, 0);
      if (chk_req) begin
        check("req_after_redirect", addr_s, chk_addr);
        chk_req = 0;
      end
      imem.gnt = !outst && ($urandom_range(99) < p_gnt);
    end
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = 9'(tgt);
    if (rd) begin
      restart(tgt);
      chk_req  = 1;
      chk_addr = ((tgt / 4) * 4) % 512;
    end
    topup();
  endtask

  task automatic check_reset_vals();
    check("rst_valid", if_id_valid, 0);
    check("rst_pc", if_id_pc, 0);
    check("rst_instr", if_id_instr, NOP_INSTR);
    check("rst_req", imem.req, 0);
    check("rst_addr", imem.addr, 0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset          = 1'b1;
    imem.gnt       = 1'b0;
    imem.rvalid    = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    outst          = 0;
    req_s          = 1'b0;
    chk_req        = 0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    restart(0);
    topup();
    chk_req  = 1;
    chk_addr = 0;
  endtask

  initial begin
    int n;
    int c0;
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem.gnt       = 1'b0;
    imem.rvalid    = 1'b0;
    imem.rdata     = '0;
    #3;
    check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    restart(0);
    topup();
    chk_req  = 1;
    chk_addr = 0;

    // Clean stream: one instruction every two cycles.
    tput_mode = 1;
    repeat (20) step(0, 0, 0);
    check("tput_progress", consumed >= 7, 1);
    tput_mode = 0;

    // Four-cycle stalls at several alignments.
    for (int k = 0; k < 3; k++) begin
      repeat (k + 1) step(0, 0, 0);
      repeat (4) step(1, 0, 0);
    end
    repeat (6) step(0, 0, 0);

    // Redirect to an unaligned target while a response is still pending.
    min_lat = 2;
    max_lat = 2;
    n = 0;
    while (!outst && n < 20) begin
      step(0, 0, 0);
      n++;
    end
    check("reach_wait_redirect", outst, 1);
    step(0, 1, 'h043);
    c0 = consumed;
    repeat (12) step(0, 0, 0);
    check("redirect_progress", consumed - c0 >= 1, 1);

    // Redirect together with stall while IF/ID is live.
    min_lat = 0;
    max_lat = 0;
    n = 0;
    while (!if_id_valid && n < 20) begin
      step(0, 0, 0);
      n++;
    end
    check("reach_ifid_valid", if_id_valid, 1);
    step(1, 1, 'h100);
    repeat (10) step(0, 0, 0);

    // Wrap from the top of the address space.
    tput_mode = 1;
    step(0, 1, 'h1FC);
    c0 = consumed;
    repeat (16) step(0, 0, 0);
    check("wrap_progress", consumed - c0 >= 5, 1);
    tput_mode = 0;

    // Random traffic.
    p_gnt   = 70;
    min_lat = 0;
    max_lat = 2;
    c0 = consumed;
    repeat (3000) begin
      step($urandom_range(99) < 30, $urandom_range(99) < 4, $urandom_range(511));
    end
    check("random_progress", consumed - c0 > 100, 1);

    // Reset while a request is outstanding.
    n = 0;
    while (!outst && n < 40) begin
      step(0, 0, 0);
      n++;
    end
    check("reach_wait_reset", outst, 1);
    async_reset();
    p_gnt   = 100;
    max_lat = 0;
    c0 = consumed;
    repeat (20) step(0, 0, 0);
    check("post_reset_progress", consumed - c0 >= 7, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 5-stage RISC-V pipeline.
- Owns the PC, issues requests to a handshaked instruction memory, and produces the IF/ID pipeline register that the decode stage consumes.
- Accepts a redirect (branch, jal or jalr resolved downstream) and a stall (load-use hazard from ID).
- Keeps at most one outstanding memory request.

Parameters:
- PC_W, 9, program counter and imem address width.
- INS_W, 32, instruction width.

Ports:
- clk  in  1  global clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  ID cannot accept; IF/ID register holds.
- redirect_valid  in  1  taken branch or jump; flush and reload PC.
- redirect_pc  in  PC_W  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  INS_W  fetched instruction.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_pc  out  PC_W  PC of the IF/ID instruction.
- if_id_instr  out  INS_W  IF/ID instruction.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- Reset values: pc=0, state=FS_REQ, stale=0, hold empty, imem_req=0 while reset is asserted, if_id_valid=0, if_id_pc=0, if_id_instr=32'h00000013 (NOP).
- Reset asserted mid-request: the outstanding transaction is abandoned. imem shares the same reset.
- imem_addr is always the registered request address: pc in FS_REQ, req_pc otherwise. req_pc is the address of the in-flight request.
- FS_REQ:
  - imem_req=1.
  - On imem_gnt: req_pc<=pc, pc<=pc+4 (modulo 2^PC_W, so 0x1FC wraps to 0x000), go to FS_WAIT.
- FS_WAIT:
  - imem_req=0; wait for imem_rvalid. Response latency is at least 1 cycle after gnt.
  - On rvalid with stale=1: drop the data, stale<=0, go to FS_REQ.
  - On rvalid with stale=0 and the IF/ID register free (if_id_valid=0 or stall=0): load IF/ID with {req_pc, imem_rdata}, set valid=1, go to FS_REQ.
  - On rvalid otherwise: write into the hold register, go to FS_FULL.
- FS_FULL:
  - imem_req=0.
  - When stall=0, move the hold register into IF/ID and go to FS_REQ.
- IF/ID register:
  - When stall=1 and if_id_valid=1, all if_id_* outputs hold their values.
  - When stall=0 and no new instruction is available, if_id_valid<=0 and if_id_instr<=NOP.
- Redirect (takes priority over stall, and over any response in the same cycle):
  - pc<=redirect_pc with bits [1:0] forced to 00.
  - if_id_valid<=0, if_id_instr<=NOP; hold register cleared.
  - In FS_WAIT without a same-cycle rvalid, or in FS_REQ with a same-cycle gnt: stale<=1, next state FS_WAIT.
  - In FS_WAIT with a same-cycle rvalid: that response is dropped, next state FS_REQ.
  - In FS_FULL, or in FS_REQ without gnt: next state FS_REQ.
- Throughput: with gnt and 1-cycle rvalid, one instruction every 2 cycles.

Optional Feature:
- Macro: FETCH_BUF_EN.
- Defined:
  - The hold register becomes a 2-entry FIFO, written on non-stale rvalid whenever IF/ID cannot accept.
  - FS_FULL is entered only when the FIFO is full. FS_REQ is re-entered after a response when 1 slot is free, so fetch continues through a stall.
  - IF/ID loads from the FIFO head ahead of a direct imem response, preserving program order.
  - Redirect empties the FIFO.
- Undefined: a single hold register, with fetch stopped in FS_FULL as described above.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {FS_REQ, FS_WAIT, FS_FULL}.
  - NOP_INSTR = 32'h00000013.
  - PC_STEP = 4.
  - IF/ID packed struct {valid, pc, instr}.
- Sub-module fetch_buffer holds the hold register or the FIFO:
  - Inputs: wr_en, wr_data, rd_en, clear.
  - Outputs: empty, full, rd_data.
  - Depth is 1, or 2 under FETCH_BUF_EN.

Test Plan:
- Release reset; gnt is immediate and rvalid comes 1 cycle later with instrs A, B, C. IF/ID shows (0x000,A), (0x004,B), (0x008,C) with valid=1, each 2 cycles apart.
- stall=1 for 4 cycles while B's response arrives. IF/ID holds (0x000,A) and B goes to the hold register. One cycle after stall drops, IF/ID shows (0x004,B). Next imem_addr is 0x008.
- redirect_valid to 0x043 while in FS_WAIT for 0x008. if_id_valid=0 next cycle and the late response is dropped. Next request address is 0x040, and IF/ID then shows (0x040, rdata).
- redirect_valid and stall both asserted with IF/ID valid. IF/ID is flushed (valid=0, NOP), and the next imem_addr equals the redirect target.
- Redirect to 0x1FC. Fetches go to 0x1FC then 0x000 (wrap), with the PC values correct in IF/ID.
- Assert reset in FS_WAIT. All outputs take their reset values within the same cycle, without waiting for clk. After release, the first request is to 0x000.
